// File: rtl/seq_divide_unit.sv
// Multi-cycle signed 32-bit restoring divider feeding the HI/LO registers.
// One quotient bit per clock; quotient lands in lo_out, remainder in hi_out.
module seq_divide_unit (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] lo_out,
  output logic [31:0] hi_out
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [W:0]      r_rem;
  logic [W-1:0]    r_q;
  logic [W-1:0]    r_dvs_mag;
  logic [CW-1:0]   r_cnt;
  logic            r_q_neg;
  logic            r_r_neg;
  logic            r_busy;
  logic            r_done;
  logic            r_dbz;
  logic [W-1:0]    r_lo;
  logic [W-1:0]    r_hi;

  logic            w_accept;
  logic            w_dvs_zero;
  logic [W-1:0]    w_dvd_mag;
  logic [W-1:0]    w_dvs_mag;
  logic [W:0]      w_rem_sh;
  logic [W:0]      w_trial;

  // Operand magnitudes; the most negative value maps onto itself as unsigned.
  assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_dvs_zero = (divisor == '0);
  assign w_dvd_mag  = dividend[W-1] ? W'(-dividend) : dividend;
  assign w_dvs_mag  = divisor[W-1]  ? W'(-divisor)  : divisor;

  // One restoring step: shift {rem, q} left, then trial-subtract the divisor.
  assign w_rem_sh = {r_rem[W-1:0], r_q[W-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_dvs_mag};

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next = w_dvs_zero ? S_DONE : S_CALC;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CALC: begin
        if (r_cnt == CW'(W - 1)) begin
          w_next = S_FIX;
        end
      end
      S_FIX:   w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_rem     <= '0;
      r_q       <= '0;
      r_dvs_mag <= '0;
      r_cnt     <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_lo      <= '0;
      r_hi      <= '0;
    end else if (w_accept) begin
      r_q_neg   <= dividend[W-1] ^ divisor[W-1];
      r_r_neg   <= dividend[W-1];
      r_q       <= w_dvd_mag;
      r_dvs_mag <= w_dvs_mag;
      r_rem     <= '0;
      r_cnt     <= '0;
      if (w_dvs_zero) begin
        r_lo <= '1;
        r_hi <= dividend;
      end
    end else if (r_state == S_CALC) begin
      r_rem <= w_trial[W] ? w_rem_sh : w_trial;
      r_q   <= {r_q[W-2:0], ~w_trial[W]};
      r_cnt <= r_cnt + CW'(1);
    end else if (r_state == S_FIX) begin
      r_lo <= r_q_neg ? W'(-r_q) : r_q;
      r_hi <= r_r_neg ? W'(-r_rem[W-1:0]) : r_rem[W-1:0];
    end
  end

  // Status flags registered from the next state so they line up with it.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_busy <= (w_next == S_CALC) || (w_next == S_FIX);
      r_done <= (w_next == S_DONE);
      r_dbz  <= w_accept && w_dvs_zero;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign lo_out      = r_lo;
  assign hi_out      = r_hi;

endmodule

// File: tb/tb_seq_divide_unit.sv
// Bench for seq_divide_unit: directed corners, randomized operands against an
// arithmetic reference, handshake and abort sequences.
module tb_seq_divide_unit;

  logic        clock;
  logic        clear;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] lo_out;
  logic [31:0] hi_out;

  int n_tests = 0;
  int n_fail  = 0;

  seq_divide_unit dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .lo_out      (lo_out),
    .hi_out      (hi_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Truncating signed division in plain 64-bit arithmetic.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic z);
    longint la;
    longint lb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
      q  = 32'(la / lb);
      r  = 32'(la % lb);
      z  = 1'b0;
    end
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
  endtask

  // Counts edges from the accepting edge until done is seen (bounded).
  task automatic wait_done(output int edges, output logic busy_e1);
    edges   = 0;
    busy_e1 = 1'b0;
    while (edges < 100) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      start = 1'b0;
      if (edges == 1) busy_e1 = busy;
      if (done) break;
    end
  endtask

  task automatic run_and_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] eq, input logic [31:0] er, input logic ez);
    int   edges;
    logic b1;
    issue(a, b);
    wait_done(edges, b1);
    check({tag, ".latency"}, 32'(edges), ez ? 32'd1 : 32'd34);
    check({tag, ".busy"}, 32'(b1), ez ? 32'd0 : 32'd1);
    check({tag, ".lo"}, lo_out, eq);
    check({tag, ".hi"}, hi_out, er);
    check({tag, ".dbz"}, 32'(div_by_zero), 32'(ez));
    @(posedge clock);
    @(negedge clock);
    check({tag, ".done_drop"}, 32'(done), 32'd0);
    check({tag, ".dbz_drop"}, 32'(div_by_zero), 32'd0);
    check({tag, ".lo_hold"}, lo_out, eq);
    check({tag, ".hi_hold"}, hi_out, er);
  endtask

  logic [31:0] d_a [10];
  logic [31:0] d_b [10];
  logic [31:0] d_q [10];
  logic [31:0] d_r [10];

  initial begin
    int          edges;
    int          seen;
    logic        b1;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] mq;
    logic [31:0] mr;
    logic        mz;

    clear = 1'b0; start = 1'b0; dividend = '0; divisor = '0;

    // Asynchronous reset mid-cycle.
    #2 clear = 1'b1;
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.dbz", 32'(div_by_zero), 32'd0);
    check("rst.lo", lo_out, 32'd0);
    check("rst.hi", hi_out, 32'd0);
    @(negedge clock);
    clear = 1'b0;

    d_a[0] = 32'd100;        d_b[0] = 32'd7;          d_q[0] = 32'd14;         d_r[0] = 32'd2;
    d_a[1] = -32'sd100;      d_b[1] = 32'd7;          d_q[1] = 32'hFFFF_FFF2;  d_r[1] = 32'hFFFF_FFFE;
    d_a[2] = 32'd100;        d_b[2] = -32'sd7;        d_q[2] = 32'hFFFF_FFF2;  d_r[2] = 32'd2;
    d_a[3] = -32'sd100;      d_b[3] = -32'sd7;        d_q[3] = 32'd14;         d_r[3] = 32'hFFFF_FFFE;
    d_a[4] = 32'h8000_0000;  d_b[4] = 32'hFFFF_FFFF;  d_q[4] = 32'h8000_0000;  d_r[4] = 32'd0;
    d_a[5] = 32'hFFFF_FFFF;  d_b[5] = 32'h8000_0000;  d_q[5] = 32'd0;          d_r[5] = 32'hFFFF_FFFF;
    d_a[6] = 32'd0;          d_b[6] = 32'd5;          d_q[6] = 32'd0;          d_r[6] = 32'd0;
    d_a[7] = 32'd5;          d_b[7] = 32'd0;          d_q[7] = 32'hFFFF_FFFF;  d_r[7] = 32'd5;
    d_a[8] = 32'd9;          d_b[8] = 32'd3;          d_q[8] = 32'd3;          d_r[8] = 32'd0;
    d_a[9] = 32'h7FFF_FFFF;  d_b[9] = 32'd1;          d_q[9] = 32'h7FFF_FFFF;  d_r[9] = 32'd0;

    for (int i = 0; i < 10; i++) begin
      run_and_check($sformatf("dir%0d", i), d_a[i], d_b[i], d_q[i], d_r[i], d_b[i] == 32'd0);
    end

    // Randomized operands with a mix of magnitudes and some zero divisors.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = 32'($signed($urandom_range(0, 20)) - 10);
        2:       rb = {{16{ra[31]}}, 16'($urandom)};
        default: begin ra = 32'($signed($urandom_range(0, 2000)) - 1000); rb = $urandom; end
      endcase
      model(ra, rb, mq, mr, mz);
      run_and_check($sformatf("rnd%0d", i), ra, rb, mq, mr, mz);
    end

    // start while busy is ignored.
    issue(32'd50, 32'd3);
    edges = 0;
    while (edges < 100) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      start = 1'b0;
      if (edges == 10) issue(32'd8, 32'd2);
      if (done) break;
    end
    check("hs1.latency", 32'(edges), 32'd34);
    check("hs1.lo", lo_out, 32'd16);
    check("hs1.hi", hi_out, 32'd2);

    // start in the DONE cycle is accepted back-to-back.
    issue(32'd8, 32'd2);
    wait_done(edges, b1);
    check("hs2.latency", 32'(edges), 32'd34);
    check("hs2.busy", 32'(b1), 32'd1);
    check("hs2.lo", lo_out, 32'd4);
    check("hs2.hi", hi_out, 32'd0);

    @(posedge clock);
    @(negedge clock);

    // Abort a computation with clear partway through.
    issue(32'd1000, 32'd10);
    edges = 0;
    while (edges < 15) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      start = 1'b0;
    end
    #2 clear = 1'b1;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.lo", lo_out, 32'd0);
    check("abort.hi", hi_out, 32'd0);
    @(negedge clock);
    clear = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done || busy) seen++;
    end
    check("abort.quiet", 32'(seen), 32'd0);
    run_and_check("abort2", 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
